// File: rtl/hazard_scoreboard_if.sv
// Hazard unit bus: D/E/M/W pipeline observations in, stall/flush/forward controls out.
interface hazard_scoreboard_if #(
  parameter int NREG = 32,
  parameter int NFWD = 2
);
  localparam int REGW = $clog2(NREG);
  localparam int FSEL = $clog2(NFWD + 1);

  logic [REGW-1:0]      rs_d;
  logic [REGW-1:0]      rt_d;
  logic                 use_rs_d;
  logic                 use_rt_d;
  logic                 issue_d;
  logic [REGW-1:0]      wreg_d;
  logic                 wen_d;
  logic                 long_d;
  logic [REGW-1:0]      rs_e;
  logic [REGW-1:0]      rt_e;
  logic [NFWD*REGW-1:0] wreg_fwd;
  logic [NFWD-1:0]      wen_fwd;
  logic                 wb_valid;
  logic [REGW-1:0]      wb_reg;
  logic                 i_stall;
  logic                 d_stall;
  logic                 div_stall;
  logic                 exception_en;

  logic [FSEL-1:0]      fwd_a_e;
  logic [FSEL-1:0]      fwd_b_e;
  logic                 stall_f;
  logic                 stall_d;
  logic                 stall_e;
  logic                 stall_m;
  logic                 stall_w;
  logic                 flush_d;
  logic                 flush_e;
  logic                 flush_m;
  logic                 flush_w;
  logic                 all_stall;
  logic [NREG-1:0]      sb_busy;

  modport master (
    output rs_d, rt_d, use_rs_d, use_rt_d, issue_d, wreg_d, wen_d, long_d,
           rs_e, rt_e, wreg_fwd, wen_fwd, wb_valid, wb_reg,
           i_stall, d_stall, div_stall, exception_en,
    input  fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, stall_m, stall_w,
           flush_d, flush_e, flush_m, flush_w, all_stall, sb_busy
  );

  modport slave (
    input  rs_d, rt_d, use_rs_d, use_rt_d, issue_d, wreg_d, wen_d, long_d,
           rs_e, rt_e, wreg_fwd, wen_fwd, wb_valid, wb_reg,
           i_stall, d_stall, div_stall, exception_en,
    output fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, stall_m, stall_w,
           flush_d, flush_e, flush_m, flush_w, all_stall, sb_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard unit with a per-register busy scoreboard for long-latency producers,
// a bounded outstanding-producer count, N-source forwarding into E, and an
// exception latch so an exception raised under a global stall is flushed later.
module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int NFWD     = 2,
  parameter int MAX_PEND = 4
) (
  input logic          clk,
  input logic          rst,
  hazard_scoreboard_if.slave hz
);
  localparam int REGW = $clog2(NREG);
  localparam int FSEL = $clog2(NFWD + 1);
  localparam int PCW  = $clog2(MAX_PEND + 1);
  localparam logic [PCW-1:0] PEND_FULL = PCW'(MAX_PEND);

  logic [NREG-1:0] r_busy;
  logic [PCW-1:0]  r_pend_cnt;
  logic            r_exc_pend;

  logic            w_all_stall;
  logic            w_wb_hit;
  logic            w_raw_rs;
  logic            w_raw_rt;
  logic            w_struct;
  logic            w_haz;
  logic            w_exc;
  logic            w_stall_d;
  logic            w_adv_d;
  logic            w_set;
  logic            w_flush;
  logic [NREG-1:0] w_busy_nxt;
  logic [PCW-1:0]  w_pend_nxt;
  logic [FSEL-1:0] w_fwd_a;
  logic [FSEL-1:0] w_fwd_b;

  assign w_all_stall = hz.i_stall | hz.d_stall | hz.div_stall;
  // A writeback only retires a producer if that register is actually busy.
  assign w_wb_hit    = hz.wb_valid & r_busy[hz.wb_reg];
  // Regfile is write-before-read, so a same-cycle writeback of the source resolves it.
  assign w_raw_rs    = hz.use_rs_d & r_busy[hz.rs_d] & ~(hz.wb_valid & (hz.wb_reg == hz.rs_d));
  assign w_raw_rt    = hz.use_rt_d & r_busy[hz.rt_d] & ~(hz.wb_valid & (hz.wb_reg == hz.rt_d));
  assign w_struct    = hz.issue_d & hz.wen_d & hz.long_d & (r_pend_cnt == PEND_FULL) & ~w_wb_hit;
  assign w_haz       = w_raw_rs | w_raw_rt | w_struct;
  assign w_exc       = hz.exception_en | r_exc_pend;
  assign w_stall_d   = w_haz | w_all_stall;
  assign w_adv_d     = hz.issue_d & ~w_stall_d;
  assign w_set       = w_adv_d & hz.wen_d & hz.long_d & (hz.wreg_d != '0);
  assign w_flush     = w_exc & ~w_all_stall;

  // Forward select: scan oldest to youngest so the youngest matching source wins.
  always_comb begin
    w_fwd_a = '0;
    w_fwd_b = '0;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (hz.wen_fwd[k] && (hz.wreg_fwd[k*REGW +: REGW] == hz.rs_e) && (hz.rs_e != '0))
        w_fwd_a = FSEL'(k + 1);
      if (hz.wen_fwd[k] && (hz.wreg_fwd[k*REGW +: REGW] == hz.rt_e) && (hz.rt_e != '0))
        w_fwd_b = FSEL'(k + 1);
    end
  end

  // Scoreboard next state: flush wipes everything; otherwise clear then set, so set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    w_pend_nxt = r_pend_cnt;
    if (w_flush) begin
      w_busy_nxt = '0;
      w_pend_nxt = '0;
    end else begin
      if (w_wb_hit)
        w_busy_nxt[hz.wb_reg] = 1'b0;
      if (w_set)
        w_busy_nxt[hz.wreg_d] = 1'b1;
      if (w_set && !w_wb_hit && (r_pend_cnt != PEND_FULL))
        w_pend_nxt = r_pend_cnt + PCW'(1);
      else if (!w_set && w_wb_hit && (r_pend_cnt != '0))
        w_pend_nxt = r_pend_cnt - PCW'(1);
    end
  end

  // State registers: scoreboard, pending count and the deferred-exception latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= '0;
      r_pend_cnt <= '0;
      r_exc_pend <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_pend_cnt <= w_pend_nxt;
      if (hz.exception_en && w_all_stall)
        r_exc_pend <= 1'b1;
      else if (w_flush)
        r_exc_pend <= 1'b0;
    end
  end

  assign hz.fwd_a_e   = w_fwd_a;
  assign hz.fwd_b_e   = w_fwd_b;
  assign hz.all_stall = w_all_stall;
  assign hz.stall_f   = w_stall_d & ~w_exc;
  assign hz.stall_d   = w_stall_d;
  assign hz.stall_e   = w_all_stall;
  assign hz.stall_m   = w_all_stall;
  assign hz.stall_w   = w_all_stall;
  assign hz.flush_d   = w_flush;
  assign hz.flush_e   = (w_haz | w_exc) & ~w_all_stall;
  assign hz.flush_m   = w_flush;
  assign hz.flush_w   = w_flush;
  assign hz.sb_busy   = r_busy;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a table of combinational vectors
// plus hand-written multi-cycle sequences, checked through an expectation queue.
module tb_hazard_scoreboard;
  localparam int NREG = 32;
  localparam int NFWD = 2;
  localparam int MAX_PEND = 4;

  typedef struct {
    string       name;
    logic [13:0] outs;
    logic [31:0] busy;
  } exp_t;

  typedef struct {
    string       name;
    logic [4:0]  rs_e;
    logic [4:0]  rt_e;
    logic [9:0]  wreg_fwd;
    logic [1:0]  wen_fwd;
    logic        use_rs_d;
    logic [4:0]  rs_d;
    logic        i_stall;
    logic        d_stall;
    logic        div_stall;
    logic        exc;
    logic [13:0] exp_outs;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  vec_t tbl[11];
  logic [13:0] Z, S_RAW, S_ALL, S_EXC_ST, FLUSH;
  logic [31:0] mask;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NREG(NREG), .NFWD(NFWD)) hz ();

  hazard_scoreboard #(.NREG(NREG), .NFWD(NFWD), .MAX_PEND(MAX_PEND)) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  function automatic logic [13:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic sf, input logic sd, input logic se,
                                     input logic sm, input logic sw, input logic fd,
                                     input logic fe, input logic fm, input logic fw,
                                     input logic as_);
    return {fa, fb, sf, sd, se, sm, sw, fd, fe, fm, fw, as_};
  endfunction

  function automatic logic [13:0] outs();
    return {hz.fwd_a_e, hz.fwd_b_e, hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m,
            hz.stall_w, hz.flush_d, hz.flush_e, hz.flush_m, hz.flush_w, hz.all_stall};
  endfunction

  task automatic idle();
    hz.rs_d = '0; hz.rt_d = '0; hz.use_rs_d = 1'b0; hz.use_rt_d = 1'b0;
    hz.issue_d = 1'b0; hz.wreg_d = '0; hz.wen_d = 1'b0; hz.long_d = 1'b0;
    hz.rs_e = '0; hz.rt_e = '0; hz.wreg_fwd = '0; hz.wen_fwd = '0;
    hz.wb_valid = 1'b0; hz.wb_reg = '0;
    hz.i_stall = 1'b0; hz.d_stall = 1'b0; hz.div_stall = 1'b0; hz.exception_en = 1'b0;
  endtask

  task automatic issue_long(input logic [4:0] r);
    hz.issue_d = 1'b1; hz.wen_d = 1'b1; hz.long_d = 1'b1; hz.wreg_d = r;
  endtask

  // Push the expectation for the inputs just driven, then pop and compare once settled.
  task automatic cyc(input string nm, input logic [13:0] e, input logic [31:0] eb);
    exp_t x;
    exp_t y;
    x.name = nm; x.outs = e; x.busy = eb;
    q.push_back(x);
    #2;
    y = q.pop_front();
    n_tests++;
    if (outs() !== y.outs) begin
      n_fail++;
      $display("FAIL %s: outs got %b want %b", y.name, outs(), y.outs);
    end
    n_tests++;
    if (hz.sb_busy !== y.busy) begin
      n_fail++;
      $display("FAIL %s: sb_busy got %h want %h", y.name, hz.sb_busy, y.busy);
    end
    @(negedge clk);
  endtask

  task automatic set_vec(input int i, input string nm, input logic [4:0] rse, input logic [4:0] rte,
                         input logic [9:0] wf, input logic [1:0] wn, input logic urs,
                         input logic [4:0] rsd, input logic is_, input logic ds,
                         input logic vs, input logic ex, input logic [13:0] e);
    tbl[i].name = nm; tbl[i].rs_e = rse; tbl[i].rt_e = rte; tbl[i].wreg_fwd = wf;
    tbl[i].wen_fwd = wn; tbl[i].use_rs_d = urs; tbl[i].rs_d = rsd; tbl[i].i_stall = is_;
    tbl[i].d_stall = ds; tbl[i].div_stall = vs; tbl[i].exc = ex; tbl[i].exp_outs = e;
  endtask

  initial begin
    Z        = 14'd0;
    S_RAW    = mk(2'd0, 2'd0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    S_ALL    = mk(2'd0, 2'd0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1);
    S_EXC_ST = mk(2'd0, 2'd0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1);
    FLUSH    = mk(2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0);

    set_vec(0,  "fwd_m_youngest", 5'd3, 5'd0, {5'd3, 5'd3}, 2'b11, 0, 5'd0, 0, 0, 0, 0,
            mk(2'd1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    set_vec(1,  "fwd_w_only",     5'd3, 5'd0, {5'd3, 5'd3}, 2'b10, 0, 5'd0, 0, 0, 0, 0,
            mk(2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    set_vec(2,  "fwd_rs_zero",    5'd0, 5'd0, {5'd0, 5'd0}, 2'b11, 0, 5'd0, 0, 0, 0, 0, Z);
    set_vec(3,  "fwd_split",      5'd7, 5'd9, {5'd7, 5'd9}, 2'b11, 0, 5'd0, 0, 0, 0, 0,
            mk(2'd2, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    set_vec(4,  "fwd_rt_only",    5'd1, 5'd4, {5'd4, 5'd4}, 2'b11, 0, 5'd0, 0, 0, 0, 0,
            mk(2'd0, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    set_vec(5,  "fwd_disabled",   5'd3, 5'd3, {5'd3, 5'd3}, 2'b00, 0, 5'd0, 0, 0, 0, 0, Z);
    set_vec(6,  "raw_idle_sb",    5'd0, 5'd0, 10'd0,        2'b00, 1, 5'd5, 0, 0, 0, 0, Z);
    set_vec(7,  "i_stall_fwd",    5'd3, 5'd0, {5'd0, 5'd3}, 2'b01, 0, 5'd0, 1, 0, 0, 0,
            mk(2'd1, 2'd0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1));
    set_vec(8,  "d_stall",        5'd0, 5'd0, 10'd0,        2'b00, 0, 5'd0, 0, 1, 0, 0, S_ALL);
    set_vec(9,  "div_stall",      5'd0, 5'd0, 10'd0,        2'b00, 0, 5'd0, 0, 0, 1, 0, S_ALL);
    set_vec(10, "exc_free",       5'd0, 5'd0, 10'd0,        2'b00, 0, 5'd0, 0, 0, 0, 1, FLUSH);

    idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cyc("reset_state", Z, 32'h0);
    rst = 1'b0;
    cyc("post_reset", Z, 32'h0);

    for (int i = 0; i < 11; i++) begin
      idle();
      hz.rs_e = tbl[i].rs_e; hz.rt_e = tbl[i].rt_e;
      hz.wreg_fwd = tbl[i].wreg_fwd; hz.wen_fwd = tbl[i].wen_fwd;
      hz.use_rs_d = tbl[i].use_rs_d; hz.rs_d = tbl[i].rs_d;
      hz.i_stall = tbl[i].i_stall; hz.d_stall = tbl[i].d_stall;
      hz.div_stall = tbl[i].div_stall; hz.exception_en = tbl[i].exc;
      cyc(tbl[i].name, tbl[i].exp_outs, 32'h0);
    end
    idle();
    cyc("table_quiet", Z, 32'h0);

    // Load-use on r5 until its writeback arrives.
    idle(); issue_long(5'd5);
    cyc("load_r5_issue", Z, 32'h0);
    for (int i = 0; i < 2; i++) begin
      idle(); hz.issue_d = 1'b1; hz.use_rs_d = 1'b1; hz.rs_d = 5'd5;
      cyc("raw_r5_stall", S_RAW, 32'h20);
    end
    idle(); hz.issue_d = 1'b1; hz.use_rs_d = 1'b1; hz.rs_d = 5'd5;
    hz.wb_valid = 1'b1; hz.wb_reg = 5'd5;
    cyc("raw_r5_wb_bypass", Z, 32'h20);
    idle();
    cyc("raw_r5_cleared", Z, 32'h0);

    // Fill the pending window, then release a slot with a same-cycle writeback.
    mask = 32'h0;
    for (int r = 1; r <= 4; r++) begin
      idle(); issue_long(5'(r));
      cyc("sb_fill", Z, mask);
      mask[r] = 1'b1;
    end
    idle(); issue_long(5'd6);
    cyc("struct_full", S_RAW, 32'h1E);
    hz.wb_valid = 1'b1; hz.wb_reg = 5'd2;
    cyc("struct_wb_release", Z, 32'h1E);
    idle(); issue_long(5'd7);
    cyc("struct_still_full", S_RAW, 32'h5A);
    idle(); hz.exception_en = 1'b1;
    cyc("flush_clears_sb", FLUSH, 32'h5A);
    idle();
    cyc("after_flush", Z, 32'h0);

    // Exception under d_stall is deferred until the stall drops.
    idle(); issue_long(5'd9);
    cyc("exc_setup", Z, 32'h0);
    idle(); hz.exception_en = 1'b1; hz.d_stall = 1'b1;
    cyc("exc_in_stall", S_EXC_ST, 32'h200);
    for (int i = 0; i < 2; i++) begin
      idle(); hz.d_stall = 1'b1;
      cyc("exc_held", S_EXC_ST, 32'h200);
    end
    idle();
    cyc("exc_flush_pulse", FLUSH, 32'h200);
    idle();
    cyc("exc_done", Z, 32'h0);

    // Set and clear of r7 in the same cycle: set wins, count unchanged.
    idle(); issue_long(5'd7);
    cyc("set_r7", Z, 32'h0);
    idle(); issue_long(5'd7); hz.wb_valid = 1'b1; hz.wb_reg = 5'd7;
    hz.use_rs_d = 1'b1; hz.rs_d = 5'd7;
    cyc("set_clr_same", Z, 32'h80);
    mask = 32'h80;
    for (int r = 1; r <= 3; r++) begin
      idle(); issue_long(5'(r));
      cyc("cnt_fill", Z, mask);
      mask[r] = 1'b1;
    end
    idle(); issue_long(5'd10);
    cyc("cnt_kept", S_RAW, 32'h8E);

    // Async reset in the middle of a stall with an exception latched.
    idle(); hz.exception_en = 1'b1; hz.d_stall = 1'b1;
    cyc("exc_before_rst", S_EXC_ST, 32'h8E);
    idle(); hz.d_stall = 1'b1;
    #1 rst = 1'b1;
    cyc("rst_mid_stall", S_ALL, 32'h0);
    rst = 1'b0;
    idle();
    cyc("after_async_rst", Z, 32'h0);
    mask = 32'h0;
    for (int r = 1; r <= 4; r++) begin
      idle(); issue_long(5'(r));
      cyc("cnt_zero_fill", Z, mask);
      mask[r] = 1'b1;
    end
    idle(); issue_long(5'd11);
    cyc("cnt_zero_full", S_RAW, 32'h1E);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
